// File: rtl/mips_multicycle_fsm_pkg.sv
// ============================================================================
// Module      : mips_multicycle_fsm_pkg
// Description : Shared types and encodings for the multicycle MIPS control FSM:
//               state enum, opcode/funct constants, ALU and mux encodings, and
//               the per-state Moore control decode.
//               Compile-time switch: MIPS_MC_JUMP_EN enables the JUMP state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_multicycle_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // srcB mux
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // next-PC mux
  localparam logic [1:0] PC_ALURES = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Control bits that depend on the state alone and can be registered.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       pcen;
    logic       instr_done;
  } moore_ctrl_t;

  // Moore control word for a state; anything not named for a state is 0.
  function automatic moore_ctrl_t moore_ctrl(input state_t s);
    moore_ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.alusrcb    = SRCB_FOUR;
        c.alucontrol = ALU_ADD;
      end
      S_DECODE: begin
        c.alusrcb    = SRCB_IMMSH;
        c.alucontrol = ALU_ADD;
      end
      S_MEMADR: begin
        c.alusrca    = 1'b1;
        c.alusrcb    = SRCB_IMM;
        c.alucontrol = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite   = 1'b1;
        c.memtoreg   = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req  = 1'b1;
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXEC: begin
        // alucontrol here comes from the funct decoder, not this word
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_REG;
      end
      S_ALUWB: begin
        c.regwrite   = 1'b1;
        c.regdst     = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca    = 1'b1;
        c.alusrcb    = SRCB_REG;
        c.alucontrol = ALU_SUB;
        c.pcsrc      = PC_ALUOUT;
        c.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        c.alusrca    = 1'b1;
        c.alusrcb    = SRCB_IMM;
        c.alucontrol = ALU_ADD;
      end
      S_ADDIWB: begin
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
      end
`ifdef MIPS_MC_JUMP_EN
      S_JUMP: begin
        c.pcsrc      = PC_JUMP;
        c.pcen       = 1'b1;
        c.instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_multicycle_fsm_alu_decoder.sv
// ============================================================================
// Module      : mips_alu_decoder
// Description : R-type funct to ALU operation decode; flags unsupported funct
//               codes (which fall back to add).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_alu_decoder
  import mips_multicycle_fsm_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_illegal
);

  // Table lookup of the five supported R-type operations
  always_comb begin
    alucontrol    = ALU_ADD;
    funct_illegal = 1'b0;
    case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_SLT:  alucontrol = ALU_SLT;
      default: funct_illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_fsm.sv
// ============================================================================
// Module      : mips_multicycle_fsm
// Description : Control FSM for a multicycle MIPS datapath sharing one memory
//               port between instruction fetch and data access. Moore control
//               bits are registered alongside the state; memory-handshake,
//               branch and decode-dependent bits are combinational.
//               Compile-time switch: MIPS_MC_JUMP_EN (j instruction support).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_fsm
  import mips_multicycle_fsm_pkg::*;
#(
  parameter int STATE_W = 4   // must be >= 4 to hold every state
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic               pcen,
  output logic [2:0]         alucontrol,
  output logic               instr_done,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);

  state_t      state_q, state_d;
  moore_ctrl_t ctrl_q, ctrl_d;
  logic        opcode_illegal;
  logic [2:0]  exec_alu;
  logic        funct_illegal;
  logic        in_fetch, in_decode, in_exec, in_branch, in_memwr;

  mips_alu_decoder u_alu_decoder (
    .funct         (funct),
    .alucontrol    (exec_alu),
    .funct_illegal (funct_illegal)
  );

  // Next-state selection; the control word for the next state is precomputed
  // so the registered outputs line up with the state they belong to.
  always_comb begin
    state_d        = S_FETCH;
    opcode_illegal = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
`ifdef MIPS_MC_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            state_d        = S_FETCH;
            opcode_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
`ifdef MIPS_MC_JUMP_EN
      S_JUMP:   state_d = S_FETCH;
`endif
      // unused encodings recover to FETCH
      default:  state_d = S_FETCH;
    endcase
    ctrl_d = moore_ctrl(state_d);
  end

  // State register and registered Moore outputs; reset drops straight to FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ctrl_q  <= moore_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // State flags for the input-dependent outputs
  always_comb begin
    in_fetch  = (state_q == S_FETCH);
    in_decode = (state_q == S_DECODE);
    in_exec   = (state_q == S_EXEC);
    in_branch = (state_q == S_BRANCH);
    in_memwr  = (state_q == S_MEMWR);
  end

  assign mem_req    = ctrl_q.mem_req;
  assign iord       = ctrl_q.iord;
  assign memwrite   = ctrl_q.memwrite;
  assign regwrite   = ctrl_q.regwrite;
  assign regdst     = ctrl_q.regdst;
  assign memtoreg   = ctrl_q.memtoreg;
  assign alusrca    = ctrl_q.alusrca;
  assign alusrcb    = ctrl_q.alusrcb;
  assign pcsrc      = ctrl_q.pcsrc;
  assign alucontrol = in_exec ? exec_alu : ctrl_q.alucontrol;

  // The fetch completion strobes are held off while reset is asserted so no
  // PC/IR update happens before the first post-reset edge.
  assign irwrite    = in_fetch & mem_ready & rst_n;
  assign pcen       = ctrl_q.pcen | (in_fetch & mem_ready & rst_n) | (in_branch & zero);
  assign instr_done = ctrl_q.instr_done | (in_memwr & mem_ready);
  assign illegal    = (in_decode & opcode_illegal) | (in_exec & funct_illegal);
  assign state_o    = STATE_W'(state_q);

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_fsm.sv
// ============================================================================
// Module      : tb_mips_multicycle_fsm
// Description : Scoreboard bench for mips_multicycle_fsm. The driver issues
//               instructions with chosen memory stall counts and pushes the
//               expected per-instruction behaviour; a negedge monitor gathers
//               what the control outputs did over each instruction and
//               compares on the return to FETCH.
//               Honours MIPS_MC_JUMP_EN in its reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_multicycle_fsm;
  import mips_multicycle_fsm_pkg::*;

  localparam int STATE_W = 4;
  localparam int MAX_CYC = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, mem_ready = 1'b1;
  logic mem_req, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic pcen, instr_done, illegal;
  logic [2:0] alucontrol;
  logic [STATE_W-1:0] state_o;

  mips_multicycle_fsm #(.STATE_W(STATE_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen),
    .alucontrol(alucontrol), .instr_done(instr_done), .illegal(illegal),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // What one instruction looks like from the outside
  typedef struct {
    int         cycles;     // FETCH (incl. stalls) up to the next FETCH
    int         done_cnt;
    int         ill_cnt;
    int         rw_cnt;
    int         mw_cnt;
    int         ir_cnt;
    int         fpcen_cnt;  // pcen together with irwrite
    int         bpcen_cnt;  // pcen without irwrite (branch/jump)
    logic [1:0] bpcsrc;
    logic       memtoreg_w;
    logic       regdst_w;
    logic [3:0] exec_alu;   // {seen, op} for the register-register ALU cycle
  } obs_t;

  obs_t sb[$];
  obs_t acc;
  int   n_tests = 0, n_fail = 0, txn_id = 0;
  bit   mon_en = 1'b0, prev_nf = 1'b0;

  function automatic obs_t blank();
    obs_t o;
    o.cycles = 0; o.done_cnt = 0; o.ill_cnt = 0; o.rw_cnt = 0; o.mw_cnt = 0;
    o.ir_cnt = 0; o.fpcen_cnt = 0; o.bpcen_cnt = 0; o.bpcsrc = 2'b00;
    o.memtoreg_w = 1'b0; o.regdst_w = 1'b0; o.exec_alu = 4'h0;
    return o;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // {bad, op} for a funct code
  function automatic logic [3:0] alu_for(input logic [5:0] f);
    case (f)
      6'h20:   return 4'b0_010;
      6'h22:   return 4'b0_110;
      6'h24:   return 4'b0_000;
      6'h25:   return 4'b0_001;
      6'h2a:   return 4'b0_111;
      default: return 4'b1_010;
    endcase
  endfunction

  // Reference: instruction class -> latency and side effects
  function automatic obs_t model(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input int fst, input int dst);
    obs_t e;
    logic [3:0] a;
    e = blank();
    e.ir_cnt = 1; e.fpcen_cnt = 1; e.done_cnt = 1;
    case (op)
      6'h23: begin e.cycles = 5 + dst; e.rw_cnt = 1; e.memtoreg_w = 1'b1; end
      6'h2b: begin e.cycles = 4 + dst; e.mw_cnt = dst + 1; end
      6'h00: begin
        a = alu_for(fn);
        e.cycles = 4; e.rw_cnt = 1; e.regdst_w = 1'b1;
        e.exec_alu = {1'b1, a[2:0]}; e.ill_cnt = int'(a[3]);
      end
      6'h04: begin
        e.cycles = 3;
        if (z) begin e.bpcen_cnt = 1; e.bpcsrc = 2'b01; end
      end
      6'h08: begin e.cycles = 4; e.rw_cnt = 1; end
      6'h02: begin
`ifdef MIPS_MC_JUMP_EN
        e.cycles = 3; e.bpcen_cnt = 1; e.bpcsrc = 2'b10;
`else
        e.cycles = 2; e.done_cnt = 0; e.ill_cnt = 1;
`endif
      end
      default: begin e.cycles = 2; e.done_cnt = 0; e.ill_cnt = 1; end
    endcase
    e.cycles += fst;
    return e;
  endfunction

  task automatic close_txn(input obs_t a);
    obs_t e;
    string p;
    p = $sformatf("txn%0d", txn_id);
    txn_id++;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s.unexpected: got an instruction, expected none queued", p);
    end else begin
      e = sb.pop_front();
      check({p, ".cycles"},     a.cycles,          e.cycles);
      check({p, ".instr_done"}, a.done_cnt,        e.done_cnt);
      check({p, ".illegal"},    a.ill_cnt,         e.ill_cnt);
      check({p, ".regwrite"},   a.rw_cnt,          e.rw_cnt);
      check({p, ".memwrite"},   a.mw_cnt,          e.mw_cnt);
      check({p, ".irwrite"},    a.ir_cnt,          e.ir_cnt);
      check({p, ".fetch_pcen"}, a.fpcen_cnt,       e.fpcen_cnt);
      check({p, ".br_pcen"},    a.bpcen_cnt,       e.bpcen_cnt);
      check({p, ".br_pcsrc"},   int'(a.bpcsrc),    int'(e.bpcsrc));
      check({p, ".memtoreg"},   int'(a.memtoreg_w), int'(e.memtoreg_w));
      check({p, ".regdst"},     int'(a.regdst_w),  int'(e.regdst_w));
      check({p, ".exec_alu"},   int'(a.exec_alu),  int'(e.exec_alu));
    end
  endtask

  // Monitor: accumulate per-instruction activity, close on return to FETCH
  always @(negedge clk) begin
    if (!mon_en) begin
      acc     = blank();
      prev_nf = 1'b0;
    end else begin
      if (state_o == STATE_W'(S_FETCH) && prev_nf) begin
        close_txn(acc);
        acc = blank();
      end
      acc.cycles++;
      if (instr_done) acc.done_cnt++;
      if (illegal)    acc.ill_cnt++;
      if (memwrite)   acc.mw_cnt++;
      if (irwrite)    acc.ir_cnt++;
      if (pcen && irwrite) acc.fpcen_cnt++;
      if (pcen && !irwrite) begin acc.bpcen_cnt++; acc.bpcsrc = pcsrc; end
      if (regwrite) begin
        acc.rw_cnt++; acc.memtoreg_w = memtoreg; acc.regdst_w = regdst;
      end
      if (alusrca && alusrcb == 2'b00 && pcsrc == 2'b00)
        acc.exec_alu = {1'b1, alucontrol};
      prev_nf = (state_o != STATE_W'(S_FETCH));
    end
  end

  // Driver: entered at posedge+1 with the FSM in FETCH; returns the same way
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int fst, input int dst);
    int left, n;
    opcode = op; funct = fn; zero = z;
    sb.push_back(model(op, fn, z, fst, dst));
    repeat (fst) begin mem_ready = 1'b0; @(posedge clk); #1; end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    left = dst; n = 0;
    while (state_o != STATE_W'(S_FETCH) && n < MAX_CYC) begin
      if (mem_req) begin
        if (left > 0) begin mem_ready = 1'b0; left--; end
        else mem_ready = 1'b1;
      end else begin
        mem_ready = 1'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    if (n >= MAX_CYC) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: op %0h still busy after %0d cycles, expected FETCH", op, n);
    end
  endtask

  function automatic logic [5:0] rand_bad_op();
    logic [5:0] o;
    do o = 6'($urandom);
    while (o == 6'h00 || o == 6'h23 || o == 6'h2b || o == 6'h04 || o == 6'h08 || o == 6'h02);
    return o;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op, fn;
    int cls, n;

    // ---------------- reset state ----------------
    #1 rst_n = 1'b0;
    #2;
    check("rst.state",      int'(state_o),    0);
    check("rst.instr_done", int'(instr_done), 0);
    check("rst.illegal",    int'(illegal),    0);
    check("rst.regwrite",   int'(regwrite),   0);
    check("rst.memwrite",   int'(memwrite),   0);
    check("rst.pcen",       int'(pcen),       0);
    check("rst.irwrite",    int'(irwrite),    0);
    check("rst.mem_req",    int'(mem_req),    1);
    check("rst.alusrcb",    int'(alusrcb),    1);
    repeat (2) @(posedge clk);
    #1;
    check("rst.state_held", int'(state_o), 0);
    rst_n = 1'b1; mon_en = 1'b1;

    // ---------------- directed ----------------
    run_instr(6'h00, 6'h20, 1'b0, 0, 0);   // add, no stalls
    run_instr(6'h23, 6'h00, 1'b0, 0, 3);   // lw, 3 stalls in MEMRD
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
    run_instr(6'h04, 6'h00, 1'b0, 0, 0);   // beq not taken
    run_instr(6'h3f, 6'h20, 1'b0, 0, 0);   // unsupported opcode
    run_instr(6'h02, 6'h00, 1'b0, 0, 0);   // j
    run_instr(6'h2b, 6'h00, 1'b0, 2, 2);   // sw, fetch and data stalls
    run_instr(6'h00, 6'h3f, 1'b0, 1, 0);   // R-type, unsupported funct
    run_instr(6'h08, 6'h00, 1'b1, 0, 0);   // addi

    // ---------------- randomized ----------------
    for (int i = 0; i < 60; i++) begin
      cls = $urandom_range(0, 6);
      case (cls)
        0: op = 6'h23;
        1: op = 6'h2b;
        2: op = 6'h00;
        3: op = 6'h04;
        4: op = 6'h08;
        5: op = 6'h02;
        default: op = rand_bad_op();
      endcase
      case ($urandom_range(0, 5))
        0: fn = 6'h20;
        1: fn = 6'h22;
        2: fn = 6'h24;
        3: fn = 6'h25;
        4: fn = 6'h2a;
        default: fn = 6'($urandom);
      endcase
      run_instr(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 4));
    end

    @(negedge clk);
    #1;
    check("sb.drained", sb.size(), 0);
    mon_en = 1'b0;

    // ---------------- reset during a stalled store ----------------
    opcode = 6'h2b; funct = 6'h00; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    n = 0;
    while (!memwrite && n < 10) begin @(posedge clk); #1; n++; end
    check("mrst.reached_memwr", int'(memwrite), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst.state",    int'(state_o),  0);
    check("mrst.memwrite", int'(memwrite), 0);
    check("mrst.regwrite", int'(regwrite), 0);
    mem_ready = 1'b1;
    #1;
    check("mrst.pcen",     int'(pcen),    0);
    check("mrst.irwrite",  int'(irwrite), 0);
    @(posedge clk); #1;
    check("mrst.state_held", int'(state_o), 0);
    rst_n = 1'b1; mon_en = 1'b1;
    run_instr(6'h08, 6'h00, 1'b0, 0, 0);   // first fetch after release
    @(negedge clk);
    #1;
    check("sb.drained_end", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
